// File: rtl/m5_ddram_pkg.sv
// Shared definitions for the Sord M5 DDRAM arbiter: FSM states, default image base
// and the byte-lane selector used on cached and freshly returned 64-bit words.
package m5_ddram_pkg;

    localparam logic [28:0] BASE_ADDR_DEF = 29'h0600_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_WAIT,
        ST_DRAIN
    } state_e;

    function automatic logic [7:0] lane_sel(input logic [63:0] word, input logic [2:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/m5_ddram_arbiter.sv
// Arbitrates the ioctl byte writer and the tape byte reader onto one 64-bit DDRAM port,
// with a single-word read cache so sequential tape reads hit DDRAM once per 8 bytes.
module m5_ddram_arbiter
    import m5_ddram_pkg::*;
#(
    parameter logic [28:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          ADDR_W    = 25
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    output logic              wr_ack_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic              rd_ack_o,
    output logic              DDRAM_CLK,
    input  logic              DDRAM_BUSY,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [28:0]       DDRAM_ADDR,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic              DDRAM_RD,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    output logic              DDRAM_WE
);

    localparam int TAG_W = ADDR_W - 3;

    state_e            state_q;
    logic              wr_ack_q;
    logic              rd_ack_q;
    logic [7:0]        rd_data_q;
    logic              ddr_rd_q;
    logic              ddr_we_q;
    logic [7:0]        ddr_be_q;
    logic [63:0]       ddr_din_q;
    logic [28:0]       ddr_addr_q;
    logic [63:0]       cache_word_q;
    logic [TAG_W-1:0]  cache_tag_q;
    logic              cache_valid_q;
    logic              rd_pending_q;
    logic [TAG_W-1:0]  rd_tag_q;
    logic [2:0]        rd_idx_q;

    logic              wr_go;
    logic              rd_go;
    logic              rd_hit;
    logic              pending_after_rst;

    // Wraps modulo 2^29 by virtue of the 29-bit result.
    function automatic logic [28:0] word_addr(input logic [TAG_W-1:0] tag);
        return BASE_ADDR + 29'(tag);
    endfunction

    // A request still high during its own ack cycle is the one just served.
    assign wr_go  = wr_req_i && !wr_ack_q;
    assign rd_go  = rd_req_i && !rd_ack_q;
    assign rd_hit = cache_valid_q && (cache_tag_q == rd_addr_i[ADDR_W-1:3]);

    // A read command is in flight if it was already pending (and its data is not arriving
    // right now) or if the controller is taking the command on this very edge.
    assign pending_after_rst = rd_pending_q ? !DDRAM_DOUT_READY : (ddr_rd_q && !DDRAM_BUSY);

    always_ff @(posedge clk_i) begin
        wr_ack_q <= 1'b0;
        rd_ack_q <= 1'b0;
        if (reset_i) begin
            state_q       <= pending_after_rst ? ST_DRAIN : ST_IDLE;
            rd_pending_q  <= pending_after_rst;
            rd_data_q     <= 8'h00;
            ddr_rd_q      <= 1'b0;
            ddr_we_q      <= 1'b0;
            ddr_be_q      <= 8'h00;
            ddr_din_q     <= 64'h0;
            ddr_addr_q    <= BASE_ADDR;
            cache_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_go) begin
                        ddr_we_q   <= 1'b1;
                        ddr_addr_q <= word_addr(wr_addr_i[ADDR_W-1:3]);
                        ddr_din_q  <= {8{wr_data_i}};
                        ddr_be_q   <= 8'b1 << wr_addr_i[2:0];
                        if (cache_valid_q && cache_tag_q == wr_addr_i[ADDR_W-1:3]) begin
                            cache_valid_q <= 1'b0;
                        end
                        state_q    <= ST_WRITE;
                    end else if (rd_go) begin
                        if (rd_hit) begin
                            rd_data_q <= lane_sel(cache_word_q, rd_addr_i[2:0]);
                            rd_ack_q  <= 1'b1;
                        end else begin
                            ddr_rd_q   <= 1'b1;
                            ddr_addr_q <= word_addr(rd_addr_i[ADDR_W-1:3]);
                            rd_tag_q   <= rd_addr_i[ADDR_W-1:3];
                            rd_idx_q   <= rd_addr_i[2:0];
                            state_q    <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!DDRAM_BUSY) begin
                        ddr_we_q <= 1'b0;
                        wr_ack_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (!DDRAM_BUSY) begin
                        ddr_rd_q     <= 1'b0;
                        rd_pending_q <= 1'b1;
                        state_q      <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        cache_word_q  <= DDRAM_DOUT;
                        cache_tag_q   <= rd_tag_q;
                        cache_valid_q <= 1'b1;
                        rd_pending_q  <= 1'b0;
                        rd_data_q     <= lane_sel(DDRAM_DOUT, rd_idx_q);
                        rd_ack_q      <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Data belongs to a pre-reset request: discard it.
                    if (DDRAM_DOUT_READY) begin
                        rd_pending_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_ack_o       = wr_ack_q;
    assign rd_ack_o       = rd_ack_q;
    assign rd_data_o      = rd_data_q;
    assign DDRAM_CLK      = clk_i;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = ddr_addr_q;
    assign DDRAM_RD       = ddr_rd_q;
    assign DDRAM_DIN      = ddr_din_q;
    assign DDRAM_BE       = ddr_be_q;
    assign DDRAM_WE       = ddr_we_q;

endmodule

// File: tb/tb_m5_ddram_arbiter.sv
// Randomized self-checking bench for m5_ddram_arbiter: a byte-level memory model and a
// one-word hit predictor against a DDRAM responder with random stalls and latency.
module tb_m5_ddram_arbiter;

    localparam logic [28:0] BASE   = 29'h0600_0000;
    localparam logic [28:0] BASE_W = 29'h1FFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        wr_req, rd_req;
    logic [24:0] wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic        DDRAM_BUSY, DDRAM_DOUT_READY;
    logic [63:0] DDRAM_DOUT;

    logic        wr_ack, rd_ack, DDRAM_CLK, DDRAM_RD, DDRAM_WE;
    logic [7:0]  rd_data, DDRAM_BURSTCNT, DDRAM_BE;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;

    logic        w_wr_ack, w_rd_ack, w_clk, w_rd, w_we;
    logic [7:0]  w_rd_data, w_burst, w_be;
    logic [28:0] w_addr;
    logic [63:0] w_din;

    m5_ddram_arbiter #(.BASE_ADDR(BASE), .ADDR_W(25)) u_dut (
        .clk_i(clk), .reset_i(reset_i),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_ack_o(rd_ack),
        .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
    );

    // Same stimulus, base chosen so the word address wraps past 2^29.
    m5_ddram_arbiter #(.BASE_ADDR(BASE_W), .ADDR_W(25)) u_dut_wrap (
        .clk_i(clk), .reset_i(reset_i),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(w_wr_ack),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(w_rd_data), .rd_ack_o(w_rd_ack),
        .DDRAM_CLK(w_clk), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(w_burst),
        .DDRAM_ADDR(w_addr), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_RD(w_rd), .DDRAM_DIN(w_din), .DDRAM_BE(w_be), .DDRAM_WE(w_we)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responder state and per-transaction expectations set by the driver.
    int          busy_budget = 0;
    int          rd_lat      = 1;
    int          resp_cnt    = 0;
    int          wr_beats    = 0;
    int          rd_cmds     = 0;
    logic [28:0] resp_addr, exp_addr, exp_addr_w, last_w_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_din;
    logic [1:0]  exp_cmd;
    logic [63:0] ddr_mem [logic [28:0]];

    // Reference model: flat byte memory plus which word the arbiter should be caching.
    logic [7:0]  ref_mem [int];
    bit          cache_ok = 1'b0;
    int          cache_tag = 0;

    function automatic logic [7:0] init_byte(input longint x);
        return 8'((x & 255) + ((x >> 8) & 255));
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(longint'(a));
    endfunction

    function automatic logic [63:0] mem_word(input logic [28:0] wa);
        logic [63:0] w;
        longint rel;
        if (ddr_mem.exists(wa)) return ddr_mem[wa];
        rel = longint'(wa) - longint'(BASE);
        for (int n = 0; n < 8; n++) w[n*8 +: 8] = init_byte(rel * 8 + n);
        return w;
    endfunction

    function automatic logic [28:0] word_addr(input logic [28:0] base, input logic [24:0] a);
        longint s;
        s = (longint'(base) + longint'(a / 8)) % (longint'(1) << 29);
        return 29'(s);
    endfunction

    // DDRAM responder: stalls, takes beats, returns read data after rd_lat cycles.
    initial begin
        logic [63:0] w;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = 64'h0;
        forever begin
            @(negedge clk);
            DDRAM_DOUT_READY = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    DDRAM_DOUT_READY = 1'b1;
                    DDRAM_DOUT = mem_word(resp_addr);
                end
            end
            DDRAM_BUSY = 1'b0;
            if (DDRAM_WE || DDRAM_RD) begin
                check_val("cmd_kind", {DDRAM_WE, DDRAM_RD}, exp_cmd);
                check_val("wrap_cmd_kind", {w_we, w_rd}, exp_cmd);
                check_val("cmd_addr", DDRAM_ADDR, exp_addr);
                check_val("wrap_cmd_addr", w_addr, exp_addr_w);
                if (busy_budget > 0) begin
                    DDRAM_BUSY = 1'b1;
                    busy_budget--;
                end else if (DDRAM_WE) begin
                    check_val("wr_be", DDRAM_BE, exp_be);
                    check_val("wr_din", DDRAM_DIN, exp_din);
                    check_val("wrap_wr_be_din", {w_be, w_din[55:0]}, {exp_be, exp_din[55:0]});
                    w = mem_word(DDRAM_ADDR);
                    for (int n = 0; n < 8; n++) if (DDRAM_BE[n]) w[n*8 +: 8] = DDRAM_DIN[n*8 +: 8];
                    ddr_mem[DDRAM_ADDR] = w;
                    wr_beats++;
                end else begin
                    check_val("one_outstanding", resp_cnt, 0);
                    resp_cnt    = rd_lat;
                    resp_addr   = DDRAM_ADDR;
                    last_w_addr = w_addr;
                    rd_cmds++;
                end
            end
        end
    end

    task automatic do_write(input logic [24:0] a, input logic [7:0] d, input int busy);
        int lat;
        int b0;
        @(negedge clk);
        b0 = wr_beats; busy_budget = busy; exp_cmd = 2'b10;
        exp_addr = word_addr(BASE, a); exp_addr_w = word_addr(BASE_W, a);
        exp_be = 8'h01 << a[2:0]; exp_din = {8{d}};
        wr_req = 1'b1; wr_addr = a; wr_data = d; lat = 0;
        do begin @(negedge clk); lat++; end while (!wr_ack && lat < 300);
        wr_req = 1'b0;
        check_val("wr_ack_seen", wr_ack, 1'b1);
        check_val("wrap_wr_ack", w_wr_ack, 1'b1);
        check_val("wr_latency", lat, 2 + busy);
        check_val("wr_beats", wr_beats - b0, 1);
        ref_mem[int'(a)] = d;
        if (cache_ok && cache_tag == int'(a / 8)) cache_ok = 1'b0;
        $display("[TB] WR addr=%h data=%h busy=%0d lat=%0d", a, d, busy, lat);
    endtask

    task automatic do_read(input logic [24:0] a, input int busy, input int dlat, input bit chk_lat);
        int lat;
        int c0;
        bit hit;
        @(negedge clk);
        hit = cache_ok && cache_tag == int'(a / 8);
        c0 = rd_cmds; busy_budget = hit ? 0 : busy; rd_lat = dlat; exp_cmd = 2'b01;
        exp_addr = word_addr(BASE, a); exp_addr_w = word_addr(BASE_W, a);
        rd_req = 1'b1; rd_addr = a; lat = 0;
        do begin @(negedge clk); lat++; end while (!rd_ack && lat < 300);
        rd_req = 1'b0;
        check_val("rd_ack_seen", rd_ack, 1'b1);
        check_val("wrap_rd_ack", w_rd_ack, 1'b1);
        check_val("rd_data", rd_data, ref_byte(int'(a)));
        check_val("wrap_rd_data", w_rd_data, ref_byte(int'(a)));
        check_val("rd_ddram_cmds", rd_cmds - c0, hit ? 0 : 1);
        if (chk_lat) check_val("rd_latency", lat, hit ? 1 : 2 + dlat + busy);
        if (!hit) begin cache_ok = 1'b1; cache_tag = int'(a / 8); end
        $display("[TB] RD addr=%h data=%h hit=%0d lat=%0d", a, rd_data, hit, lat);
    endtask

    initial begin
        int lat;
        int c0;
        reset_i = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; exp_cmd = 2'b00;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        check_val("rst_acks", {wr_ack, rd_ack, DDRAM_RD, DDRAM_WE}, 4'b0000);
        check_val("rst_rd_data", rd_data, 8'h00);
        check_val("rst_be", DDRAM_BE, 8'h00);
        check_val("rst_din", DDRAM_DIN, 64'h0);
        check_val("rst_addr", DDRAM_ADDR, BASE);
        check_val("rst_wrap_addr", w_addr, BASE_W);
        check_val("burstcnt", {DDRAM_BURSTCNT, w_burst}, 16'h0101);
        check_val("ddram_clk_low", {DDRAM_CLK, w_clk}, 2'b00);

        do_write(25'h000003, 8'hA5, 0);

        ddr_mem[BASE + 29'd2] = 64'h0706050403020100;
        for (int i = 0; i < 8; i++) ref_mem[16 + i] = 8'(i);
        do_read(25'h000010, 0, 5, 1'b1);
        for (int i = 1; i < 8; i++) do_read(25'(16 + i), 0, 5, 1'b1);

        // Simultaneous requests: write wins, then the read misses on the invalidated word.
        @(negedge clk);
        c0 = rd_cmds; busy_budget = 0; rd_lat = 4; exp_cmd = 2'b10;
        exp_addr = word_addr(BASE, 25'h13); exp_addr_w = word_addr(BASE_W, 25'h13);
        exp_be = 8'h08; exp_din = {8{8'h3C}};
        wr_req = 1'b1; wr_addr = 25'h13; wr_data = 8'h3C; rd_req = 1'b1; rd_addr = 25'h14; lat = 0;
        do begin @(negedge clk); lat++; end while (!wr_ack && lat < 50);
        check_val("both_wr_first", {wr_ack, rd_ack}, 2'b10);
        wr_req = 1'b0; exp_cmd = 2'b01; ref_mem[32'h13] = 8'h3C; cache_ok = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rd_ack && lat < 50);
        rd_req = 1'b0;
        check_val("both_rd_ack", rd_ack, 1'b1);
        check_val("both_rd_data", rd_data, ref_byte(32'h14));
        check_val("inval_miss", rd_cmds - c0, 1);
        cache_ok = 1'b1; cache_tag = 2;
        $display("[TB] WR+RD wr=13 rd=14 data=%h", rd_data);
        do_read(25'h000013, 0, 4, 1'b1);

        do_write(25'h000040, 8'h77, 4);
        do_read(25'h000048, 4, 3, 1'b1);

        // Reset while a read is outstanding: its data must be swallowed.
        @(negedge clk);
        c0 = rd_cmds; busy_budget = 0; rd_lat = 8; exp_cmd = 2'b01;
        exp_addr = word_addr(BASE, 25'h100); exp_addr_w = word_addr(BASE_W, 25'h100);
        rd_req = 1'b1; rd_addr = 25'h100;
        repeat (3) @(negedge clk);
        reset_i = 1'b1; rd_req = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        check_val("rst_mid_ack", rd_ack, 1'b0);
        check_val("rst_mid_data", rd_data, 8'h00);
        check_val("rst_mid_cmds", rd_cmds - c0, 1);
        cache_ok = 1'b0;
        $display("[TB] RESET during read of 100");
        do_read(25'h000208, 0, 3, 1'b0);

        do_read(25'h1FFFFF8, 0, 2, 1'b1);
        check_val("wrap_addr", last_w_addr, 29'h003F_FFFE);

        for (int t = 0; t < 200; t++) begin
            logic [24:0] a;
            a = ($urandom_range(0, 9) == 0) ? 25'($urandom) : 25'($urandom_range(0, 127));
            if ($urandom_range(0, 99) < 35)
                do_write(a, 8'($urandom), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(1, 6), 1'b1);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
